seg7_scan_reader: RTL

Passive reader for the multiplexed 7-segment display bus: it watches active-low segment lines and active-low digit enables and recovers the four hex nibbles being displayed. Each digit is accepted only after the bus has been stable for a programmable number of cycles. Used as a loop-back checker and readback path next to the display driver, and as the capture front end for a board-level display monitor.

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/seg7_pattern_decoder.sv | 37 +++
 rtl/seg7_scan_reader.sv | 135 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment display path.
//   SEG_HEX_0..SEG_HEX_F : active-low segment patterns (bit0=a .. bit6=g).
//                          The display driver uses the same constants.
//   scan_state_e         : sampling FSM states of the scan reader.
package seg7_pkg;

  localparam logic [6:0] SEG_HEX_0 = 7'h40;
  localparam logic [6:0] SEG_HEX_1 = 7'h79;
  localparam logic [6:0] SEG_HEX_2 = 7'h24;
  localparam logic [6:0] SEG_HEX_3 = 7'h30;
  localparam logic [6:0] SEG_HEX_4 = 7'h19;
  localparam logic [6:0] SEG_HEX_5 = 7'h12;
  localparam logic [6:0] SEG_HEX_6 = 7'h02;
  localparam logic [6:0] SEG_HEX_7 = 7'h78;
  localparam logic [6:0] SEG_HEX_8 = 7'h00;
  localparam logic [6:0] SEG_HEX_9 = 7'h10;
  localparam logic [6:0] SEG_HEX_A = 7'h08;
  localparam logic [6:0] SEG_HEX_B = 7'h03;
  localparam logic [6:0] SEG_HEX_C = 7'h27;
  localparam logic [6:0] SEG_HEX_D = 7'h21;
  localparam logic [6:0] SEG_HEX_E = 7'h06;
  localparam logic [6:0] SEG_HEX_F = 7'h0E;

  typedef enum logic {
    S_WAIT = 1'b0,
    S_HELD = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg7_pattern_decoder.sv
// seg7_pattern_decoder: combinational inverse of the segment encoding.
//   seg_i[6:0]    in  active-low segment pattern
//   nibble_o[3:0] out decoded hex value (0 when hit_o is low)
//   hit_o         out pattern is one of the sixteen legal glyphs
module seg7_pattern_decoder
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       hit_o
);

  always_comb begin
    nibble_o = 4'h0;
    hit_o    = 1'b1;
    case (seg_i)
      SEG_HEX_0: nibble_o = 4'h0;
      SEG_HEX_1: nibble_o = 4'h1;
      SEG_HEX_2: nibble_o = 4'h2;
      SEG_HEX_3: nibble_o = 4'h3;
      SEG_HEX_4: nibble_o = 4'h4;
      SEG_HEX_5: nibble_o = 4'h5;
      SEG_HEX_6: nibble_o = 4'h6;
      SEG_HEX_7: nibble_o = 4'h7;
      SEG_HEX_8: nibble_o = 4'h8;
      SEG_HEX_9: nibble_o = 4'h9;
      SEG_HEX_A: nibble_o = 4'hA;
      SEG_HEX_B: nibble_o = 4'hB;
      SEG_HEX_C: nibble_o = 4'hC;
      SEG_HEX_D: nibble_o = 4'hD;
      SEG_HEX_E: nibble_o = 4'hE;
      SEG_HEX_F: nibble_o = 4'hF;
      default:   hit_o    = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: passive reader of a multiplexed active-low 7-segment bus.
// A bus value {an, seg} is sampled once after it has been stable for
// STABLE_CYCLES cycles; the addressed digit's nibble is then captured.
//   clk_pi         in  system clock
//   rst_n_pi       in  asynchronous active-low reset
//   seg_pi[6:0]    in  segment lines, active-low, bit0=a .. bit6=g
//   an_pi[3:0]     in  digit enables, active-low, digit k -> value_o[4k+3:4k]
//   clear_pi       in  synchronous clear of all captured state
//   value_o[15:0]  out recovered value, one nibble per digit
//   digit_valid_o  out per-digit captured flags for the current frame
//   frame_valid_o  out one-cycle pulse when all four digits are captured
//   pattern_err_o  out sticky: a non-decodable pattern was sampled
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk_pi,
  input  logic        rst_n_pi,
  input  logic [6:0]  seg_pi,
  input  logic [3:0]  an_pi,
  input  logic        clear_pi,
  output logic [15:0] value_o,
  output logic [3:0]  digit_valid_o,
  output logic        frame_valid_o,
  output logic        pattern_err_o
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [10:0]   prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  scan_state_e   state_q;
  logic [15:0]   value_q, value_d;
  logic [3:0]    dv_q, dv_d;
  logic          frame_q, frame_d;
  logic          err_q, err_d;

  logic [10:0]   bus;
  logic          changed;
  logic          sample;
  logic          sel_vld;
  logic [1:0]    sel;
  logic [3:0]    nibble;
  logic          hit;

  assign bus     = {an_pi, seg_pi};
  assign changed = (bus != prev_q);

  always_comb begin
    if (changed)             cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = CNT_MAX;
    else                     cnt_d = cnt_q + 1'b1;
  end

  // Sample on the edge where the count reaches the threshold, so the
  // captured value is visible one load edge plus STABLE_CYCLES edges later.
  assign sample = (state_q == S_WAIT) && (cnt_d == CNT_MAX);

  // Only a single active digit enable addresses a nibble.
  always_comb begin
    sel_vld = 1'b1;
    sel     = 2'd0;
    case (an_pi)
      4'hE:    sel = 2'd0;
      4'hD:    sel = 2'd1;
      4'hB:    sel = 2'd2;
      4'h7:    sel = 2'd3;
      default: sel_vld = 1'b0;
    endcase
  end

  seg7_pattern_decoder u_dec (
    .seg_i    (seg_pi),
    .nibble_o (nibble),
    .hit_o    (hit)
  );

  always_comb begin
    value_d = value_q;
    // The frame pulse cycle is the last one the completed flags are shown.
    dv_d    = frame_q ? 4'h0 : dv_q;
    err_d   = err_q;
    frame_d = 1'b0;
    if (sample && sel_vld) begin
      if (hit) begin
        value_d[{sel, 2'b00} +: 4] = nibble;
        dv_d[sel]                  = 1'b1;
        frame_d                    = &dv_d;
      end else begin
        err_d     = 1'b1;
        dv_d[sel] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      prev_q  <= {4'hF, 7'h7F};
      cnt_q   <= '0;
      state_q <= S_WAIT;
      value_q <= '0;
      dv_q    <= '0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (clear_pi) begin
      prev_q  <= bus;
      cnt_q   <= '0;
      state_q <= S_WAIT;
      value_q <= '0;
      dv_q    <= '0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      prev_q  <= bus;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      dv_q    <= dv_d;
      frame_q <= frame_d;
      err_q   <= err_d;
      case (state_q)
        S_WAIT:  if (sample)  state_q <= S_HELD;
        S_HELD:  if (changed) state_q <= S_WAIT;
        default: state_q <= S_WAIT;
      endcase
    end
  end

  assign value_o       = value_q;
  assign digit_valid_o = dv_q;
  assign frame_valid_o = frame_q;
  assign pattern_err_o = err_q;

endmodule
